pov_frame_sequencer: RTL and testbench

Parametrised successor to the single-channel EEPROM-to-595 display controller. At start it loads a frame of `FRAME_LEN` bytes from an SPI EEPROM into an internal buffer. It then shifts `CHAN` bytes per column to a 74HC595 chain on every stepper pixel tick and latches them. The column pointer follows stepper direction with wrap-around. Both SPI engines are internal, mode 0 and MSB-first.

---
 rtl/pov_frame_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_pov_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pov_frame_sequencer.sv
// pov_frame_sequencer: loads a frame from an SPI EEPROM, then on each stepper
// pixel tick shifts one column of CHAN bytes into a 74HC595 chain and latches it.
//   clk, nreset          : clock, asynchronous active-low reset
//   run_nstop            : high runs, low aborts to idle
//   pixel_tick, dir      : stepper column strobe and direction (1 = forward)
//   eeprom_cs/sclk/mosi  : EEPROM SPI master outputs (mode 0, MSB first)
//   eeprom_miso          : EEPROM serial data in
//   hc595_clk/lat/dat    : 595 shift clock, storage latch, data (dir when not shifting)
//   loaded, overrun, col : frame valid, sticky dropped-tick flag, current column
module pov_frame_sequencer #(
    parameter int          FRAME_LEN       = 100,
    parameter int          CHAN            = 1,
    parameter int          ADDR_BYTES      = 3,
    parameter int unsigned START_ADDR      = 0,
    parameter int          CLK_DIV         = 1,
    parameter int          RELOAD_EACH_RUN = 1
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       run_nstop,
    input  logic       pixel_tick,
    input  logic       dir,
    input  logic       eeprom_miso,
    output logic       eeprom_cs,
    output logic       eeprom_sclk,
    output logic       eeprom_mosi,
    output logic       hc595_clk,
    output logic       hc595_lat,
    output logic       hc595_dat,
    output logic       loaded,
    output logic       overrun,
    output logic [7:0] col
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_LATCH = 3'd5;
    localparam int         AW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [7:0] LAST_COL  = 8'(FRAME_LEN / CHAN - 1);
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);
    localparam logic [7:0] LAST_CMD  = 8'(ADDR_BYTES);
    localparam logic [7:0] LAST_CHAN = 8'(CHAN - 1);
    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    // Address left-justified so the MSB-most transmitted byte is always [23:16].
    localparam logic [23:0] ADDR_INIT = 24'(START_ADDR << (8 * (3 - ADDR_BYTES)));

    logic [2:0]  state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic        sclk_q, sclk_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [23:0] addr_q, addr_d;
    logic        loaded_q, loaded_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  buf_q [FRAME_LEN];
    logic        buf_we, busy, half_end, byte_end;
    logic [31:0] k_next;
    logic [AW-1:0] rd_idx;
    logic [7:0]  rd_byte;

    // One bit engine serves both SPI ports; they are never active together.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        sclk_d    = sclk_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        addr_d    = addr_q;
        loaded_d  = loaded_q;
        overrun_d = overrun_q;
        col_d     = col_q;
        buf_we    = 1'b0;
        busy      = state_q == S_CMD || state_q == S_LOAD || state_q == S_SHIFT;
        half_end  = div_q == DIV_LAST;
        byte_end  = busy && half_end && sclk_q && bit_q == 3'd7;
        // Column bytes go out highest channel first; k_next is the next byte's position.
        k_next    = (state_q == S_SHIFT) ? 32'(byte_q) + 32'd1 : 32'd0;
        rd_idx    = AW'(32'(col_q) * 32'(CHAN) + 32'(CHAN - 1) - k_next);
        rd_byte   = buf_q[rd_idx];
        if (busy) begin
            div_d = half_end ? 4'd0 : div_q + 4'd1;
            if (half_end) begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    rx_d = {rx_q[6:0], eeprom_miso};
                end else begin
                    bit_d = bit_q + 3'd1;
                    tx_d  = {tx_q[6:0], 1'b0};
                end
            end
        end
        case (state_q)
            S_IDLE: begin
                col_d     = 8'd0;
                overrun_d = 1'b0;
                if (run_nstop) begin
                    if (RELOAD_EACH_RUN == 0 && loaded_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d  = S_CMD;
                        loaded_d = 1'b0;
                        tx_d     = 8'h03;
                        addr_d   = ADDR_INIT;
                        byte_d   = 8'd0;
                        bit_d    = 3'd0;
                        div_d    = 4'd0;
                        sclk_d   = 1'b0;
                    end
                end
            end
            S_CMD: begin
                if (byte_end) begin
                    if (byte_q == LAST_CMD) begin
                        state_d = S_LOAD;
                        byte_d  = 8'd0;
                        tx_d    = 8'h00;
                    end else begin
                        byte_d = byte_q + 8'd1;
                        tx_d   = addr_q[23:16];
                        addr_d = {addr_q[15:0], 8'h00};
                    end
                end
            end
            S_LOAD: begin
                if (byte_end) begin
                    buf_we = 1'b1;
                    if (byte_q == LAST_BYTE) begin
                        state_d  = S_RUN;
                        loaded_d = 1'b1;
                    end else begin
                        byte_d = byte_q + 8'd1;
                    end
                end
            end
            S_RUN: begin
                if (pixel_tick) begin
                    state_d = S_SHIFT;
                    tx_d    = rd_byte;
                    byte_d  = 8'd0;
                    bit_d   = 3'd0;
                    div_d   = 4'd0;
                    sclk_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                overrun_d = overrun_q | pixel_tick;
                if (byte_end) begin
                    if (byte_q == LAST_CHAN) begin
                        state_d = S_LATCH;
                    end else begin
                        byte_d = byte_q + 8'd1;
                        tx_d   = rd_byte;
                    end
                end
            end
            S_LATCH: begin
                overrun_d = overrun_q | pixel_tick;
                state_d   = S_RUN;
                col_d     = dir ? ((col_q == LAST_COL) ? 8'd0 : col_q + 8'd1)
                                : ((col_q == 8'd0) ? LAST_COL : col_q - 8'd1);
            end
            default: state_d = S_IDLE;
        endcase
        if (!run_nstop) begin
            state_d = S_IDLE;
            sclk_d  = 1'b0;
            div_d   = 4'd0;
            bit_d   = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            div_q     <= 4'd0;
            sclk_q    <= 1'b0;
            bit_q     <= 3'd0;
            byte_q    <= 8'd0;
            tx_q      <= 8'd0;
            rx_q      <= 8'd0;
            addr_q    <= 24'd0;
            loaded_q  <= 1'b0;
            overrun_q <= 1'b0;
            col_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            addr_q    <= addr_d;
            loaded_q  <= loaded_d;
            overrun_q <= overrun_d;
            col_q     <= col_d;
        end
    end

    // The full byte is already in rx_q at the falling edge that closes its last bit.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[byte_q[AW-1:0]] <= rx_q;
    end

    assign eeprom_cs   = !(state_q == S_CMD || state_q == S_LOAD);
    assign eeprom_sclk = sclk_q & !eeprom_cs;
    assign eeprom_mosi = tx_q[7] & !eeprom_cs;
    assign hc595_clk   = sclk_q & (state_q == S_SHIFT);
    assign hc595_dat   = (state_q == S_SHIFT) ? tx_q[7] : dir;
    assign hc595_lat   = state_q == S_LATCH;
    assign loaded      = loaded_q;
    assign overrun     = overrun_q;
    assign col         = col_q;
endmodule

// File: tb/tb_pov_frame_sequencer.sv
// tb_pov_frame_sequencer: directed self-checking bench for pov_frame_sequencer.
module tb_pov_frame_sequencer;
    logic clk = 0, nreset = 0, run_nstop = 0, run_nr = 0, pixel_tick = 0, dir = 1;
    logic miso = 0, miso_nr = 0;
    logic cs, sclk, mosi, hc_clk, hc_lat, hc_dat, loaded, overrun;
    logic cs_nr, sclk_nr, mosi_nr, hc_clk_nr, hc_lat_nr, hc_dat_nr, loaded_nr, overrun_nr;
    logic [7:0] col, col_nr;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    pov_frame_sequencer #(.FRAME_LEN(8), .CHAN(2), .ADDR_BYTES(2), .START_ADDR(16'h0010),
                          .CLK_DIV(1), .RELOAD_EACH_RUN(1)) dut (
        .clk(clk), .nreset(nreset), .run_nstop(run_nstop), .pixel_tick(pixel_tick), .dir(dir),
        .eeprom_miso(miso), .eeprom_cs(cs), .eeprom_sclk(sclk), .eeprom_mosi(mosi),
        .hc595_clk(hc_clk), .hc595_lat(hc_lat), .hc595_dat(hc_dat),
        .loaded(loaded), .overrun(overrun), .col(col));

    pov_frame_sequencer #(.FRAME_LEN(8), .CHAN(2), .ADDR_BYTES(2), .START_ADDR(16'h0010),
                          .CLK_DIV(1), .RELOAD_EACH_RUN(0)) dut_nr (
        .clk(clk), .nreset(nreset), .run_nstop(run_nr), .pixel_tick(pixel_tick), .dir(dir),
        .eeprom_miso(miso_nr), .eeprom_cs(cs_nr), .eeprom_sclk(sclk_nr), .eeprom_mosi(mosi_nr),
        .hc595_clk(hc_clk_nr), .hc595_lat(hc_lat_nr), .hc595_dat(hc_dat_nr),
        .loaded(loaded_nr), .overrun(overrun_nr), .col(col_nr));

    // EEPROM and 595 models, sampled mid-cycle: SCLK edges are seen as level changes.
    logic [7:0]  ee_sr, ee_byte, nr_byte;
    logic [15:0] ee_addr = 16'h0, hc_sr = 16'h0;
    logic        ee_prev = 0, nr_prev = 0, hc_prev = 0;
    int          ee_bits = 0, nr_bits = 0;
    logic [7:0]  mosi_log[$];
    logic [15:0] lat_log[$];

    always @(negedge clk) begin
        if (cs) begin
            ee_bits = 0;
            ee_prev = 0;
        end else begin
            if (sclk && !ee_prev) begin
                ee_sr = {ee_sr[6:0], mosi};
                ee_bits++;
                if (ee_bits % 8 == 0) begin
                    mosi_log.push_back(ee_sr);
                    if (ee_bits == 16) ee_addr[15:8] = ee_sr;
                    if (ee_bits == 24) ee_addr[7:0] = ee_sr;
                end
            end
            if (!sclk && ee_prev && ee_bits >= 24) begin
                ee_byte = 8'hA0 + 8'(ee_addr - 16'h0010) + 8'((ee_bits - 24) / 8);
                miso = ee_byte[7 - ((ee_bits - 24) % 8)];
            end
            ee_prev = sclk;
        end
        if (cs_nr) begin
            nr_bits = 0;
            nr_prev = 0;
        end else begin
            if (sclk_nr && !nr_prev) nr_bits++;
            if (!sclk_nr && nr_prev && nr_bits >= 24) begin
                nr_byte = 8'hA0 + 8'((nr_bits - 24) / 8);
                miso_nr = nr_byte[7 - ((nr_bits - 24) % 8)];
            end
            nr_prev = sclk_nr;
        end
        if (hc_clk && !hc_prev) hc_sr = {hc_sr[14:0], hc_dat};
        hc_prev = hc_clk;
        if (hc_lat) lat_log.push_back(hc_sr);
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL rst_cs: got %b want 1", cs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b want 0", mosi); end
        checks++; if (hc_clk !== 1'b0) begin errors++; $display("FAIL rst_hc_clk: got %b want 0", hc_clk); end
        checks++; if (hc_lat !== 1'b0) begin errors++; $display("FAIL rst_hc_lat: got %b want 0", hc_lat); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded: got %b want 0", loaded); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        checks++; if (col !== 8'd0) begin errors++; $display("FAIL rst_col: got %0d want 0", col); end
        checks++; if (hc_dat !== 1'b1) begin errors++; $display("FAIL rst_dat_dir1: got %b want 1", hc_dat); end
        dir = 0;
        @(negedge clk);
        checks++; if (hc_dat !== 1'b0) begin errors++; $display("FAIL rst_dat_dir0: got %b want 0", hc_dat); end
        nreset = 1;
        dir = 1;
        @(negedge clk);
    endtask

    task automatic test_load();
        int k, low;
        run_nstop = 1;
        k = 0;
        do begin @(negedge clk); k++; end while (cs && k < 10);
        checks++; if (k != 1) begin errors++; $display("FAIL load_cs_fall: got %0d cycles want 1", k); end
        low = 0;
        while (!cs && low < 400) begin low++; @(negedge clk); end
        checks++; if (low != 176) begin errors++; $display("FAIL load_cs_low: got %0d want 176", low); end
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL load_loaded: got %b want 1", loaded); end
        checks++; if (mosi_log.size() != 11) begin errors++; $display("FAIL load_mosi_count: got %0d want 11", mosi_log.size()); end
        for (int i = 0; i < 11 && i < mosi_log.size(); i++) begin
            logic [7:0] exp;
            exp = (i == 0) ? 8'h03 : (i == 2) ? 8'h10 : 8'h00;
            checks++; if (mosi_log[i] !== exp) begin errors++; $display("FAIL load_mosi_byte%0d: got %h want %h", i, mosi_log[i], exp); end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_forward();
        dir = 1;
        lat_log.delete();
        for (int i = 0; i < 4; i++) begin
            int k;
            logic [15:0] got, exp;
            k = 0;
            got = 'x;
            exp = {8'(161 + 2 * i), 8'(160 + 2 * i)};
            pixel_tick = 1;
            do begin @(negedge clk); pixel_tick = 0; k++; end while (!hc_lat && k < 80);
            checks++; if (k != 33) begin errors++; $display("FAIL fwd_lat_delay%0d: got %0d want 33", i, k); end
            @(negedge clk);
            checks++; if (hc_lat !== 1'b0) begin errors++; $display("FAIL fwd_lat_width%0d: got %b want 0", i, hc_lat); end
            checks++; if (col !== 8'((i + 1) % 4)) begin errors++; $display("FAIL fwd_col%0d: got %0d want %0d", i, col, (i + 1) % 4); end
            if (lat_log.size() != 0) got = lat_log.pop_front();
            checks++; if (got !== exp) begin errors++; $display("FAIL fwd_bytes%0d: got %h want %h", i, got, exp); end
            repeat (10) @(negedge clk);
        end
    endtask

    task automatic test_reverse();
        logic [15:0] exp [2];
        logic [7:0]  exp_col [2];
        exp[0] = 16'hA1A0; exp[1] = 16'hA7A6;
        exp_col[0] = 8'd3; exp_col[1] = 8'd2;
        dir = 0;
        lat_log.delete();
        @(negedge clk);
        checks++; if (hc_dat !== 1'b0) begin errors++; $display("FAIL rev_dat_dir0: got %b want 0", hc_dat); end
        for (int i = 0; i < 2; i++) begin
            int k;
            logic [15:0] got;
            k = 0;
            got = 'x;
            pixel_tick = 1;
            do begin @(negedge clk); pixel_tick = 0; k++; end while (!hc_lat && k < 80);
            checks++; if (k != 33) begin errors++; $display("FAIL rev_lat_delay%0d: got %0d want 33", i, k); end
            @(negedge clk);
            checks++; if (col !== exp_col[i]) begin errors++; $display("FAIL rev_col%0d: got %0d want %0d", i, col, exp_col[i]); end
            if (lat_log.size() != 0) got = lat_log.pop_front();
            checks++; if (got !== exp[i]) begin errors++; $display("FAIL rev_bytes%0d: got %h want %h", i, got, exp[i]); end
            repeat (5) @(negedge clk);
        end
        dir = 1;
        @(negedge clk);
        checks++; if (hc_dat !== 1'b1) begin errors++; $display("FAIL rev_dat_dir1: got %b want 1", hc_dat); end
    endtask

    task automatic test_overrun();
        int n;
        logic [15:0] got;
        got = 'x;
        dir = 1;
        lat_log.delete();
        pixel_tick = 1;
        @(negedge clk);
        pixel_tick = 0;
        repeat (9) @(negedge clk);
        pixel_tick = 1;
        @(negedge clk);
        pixel_tick = 0;
        n = 0;
        repeat (70) begin @(negedge clk); n += int'(hc_lat); end
        checks++; if (n != 1) begin errors++; $display("FAIL ovr_lat_count: got %0d want 1", n); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        checks++; if (col !== 8'd3) begin errors++; $display("FAIL ovr_col: got %0d want 3", col); end
        if (lat_log.size() != 0) got = lat_log.pop_front();
        checks++; if (got !== 16'hA5A4) begin errors++; $display("FAIL ovr_bytes: got %h want a5a4", got); end
        run_nstop = 0;
        repeat (2) @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_idle_clear: got %b want 0", overrun); end
        checks++; if (col !== 8'd0) begin errors++; $display("FAIL ovr_idle_col: got %0d want 0", col); end
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL ovr_idle_loaded: got %b want 1", loaded); end
    endtask

    task automatic test_abort();
        int low;
        run_nstop = 1;
        @(negedge clk);
        checks++; if (cs !== 1'b0) begin errors++; $display("FAIL abort_cs_start: got %b want 0", cs); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL abort_loaded_clr: got %b want 0", loaded); end
        repeat (59) @(negedge clk);
        run_nstop = 0;
        @(negedge clk);
        checks++; if (cs !== 1'b1) begin errors++; $display("FAIL abort_cs: got %b want 1", cs); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL abort_loaded: got %b want 0", loaded); end
        mosi_log.delete();
        repeat (2) @(negedge clk);
        run_nstop = 1;
        @(negedge clk);
        low = 0;
        while (!cs && low < 400) begin low++; @(negedge clk); end
        checks++; if (low != 176) begin errors++; $display("FAIL abort_reload_len: got %0d want 176", low); end
        checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL abort_reload_loaded: got %b want 1", loaded); end
        checks++; if (mosi_log.size() == 0 || mosi_log[0] !== 8'h03) begin
            errors++; $display("FAIL abort_restart_opcode: got %h want 03", (mosi_log.size() != 0) ? mosi_log[0] : 8'hxx);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_latch_edge();
        int k, n;
        logic [15:0] got;
        dir = 1;
        lat_log.delete();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL edge_ovr_pre: got %b want 0", overrun); end
        k = 0;
        pixel_tick = 1;
        do begin @(negedge clk); pixel_tick = 0; k++; end while (!hc_lat && k < 80);
        checks++; if (k != 33) begin errors++; $display("FAIL edge_lat_delay: got %0d want 33", k); end
        pixel_tick = 1;
        @(negedge clk);
        k = 0;
        do begin @(negedge clk); pixel_tick = 0; k++; end while (!hc_lat && k < 80);
        checks++; if (k != 33) begin errors++; $display("FAIL edge_reaccept_delay: got %0d want 33", k); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL edge_ovr: got %b want 1", overrun); end
        @(negedge clk);
        checks++; if (col !== 8'd2) begin errors++; $display("FAIL edge_col: got %0d want 2", col); end
        checks++; if (lat_log.size() != 2) begin errors++; $display("FAIL edge_lat_count: got %0d want 2", lat_log.size()); end
        got = (lat_log.size() == 2) ? lat_log[1] : 16'hxxxx;
        checks++; if (got !== 16'hA3A2) begin errors++; $display("FAIL edge_bytes: got %h want a3a2", got); end
        repeat (5) @(negedge clk);
        pixel_tick = 1;
        @(negedge clk);
        pixel_tick = 0;
        repeat (9) @(negedge clk);
        run_nstop = 0;
        n = 0;
        repeat (40) begin @(negedge clk); n += int'(hc_lat); end
        checks++; if (n != 0) begin errors++; $display("FAIL abort_shift_lat: got %0d want 0", n); end
        checks++; if (hc_clk !== 1'b0) begin errors++; $display("FAIL abort_shift_clk: got %b want 0", hc_clk); end
    endtask

    task automatic test_no_reload();
        int k, low;
        dir = 1;
        run_nr = 1;
        k = 0;
        do begin @(negedge clk); k++; end while (cs_nr && k < 10);
        low = 0;
        while (!cs_nr && low < 400) begin low++; @(negedge clk); end
        checks++; if (low != 176) begin errors++; $display("FAIL nr_load_len: got %0d want 176", low); end
        checks++; if (loaded_nr !== 1'b1) begin errors++; $display("FAIL nr_loaded: got %b want 1", loaded_nr); end
        k = 0;
        pixel_tick = 1;
        do begin @(negedge clk); pixel_tick = 0; k++; end while (!hc_lat_nr && k < 80);
        @(negedge clk);
        checks++; if (col_nr !== 8'd1) begin errors++; $display("FAIL nr_col_adv: got %0d want 1", col_nr); end
        run_nr = 0;
        repeat (3) @(negedge clk);
        checks++; if (col_nr !== 8'd0) begin errors++; $display("FAIL nr_col_idle: got %0d want 0", col_nr); end
        run_nr = 1;
        @(negedge clk);
        low = int'(!cs_nr);
        k = 0;
        pixel_tick = 1;
        do begin @(negedge clk); pixel_tick = 0; k++; low += int'(!cs_nr); end while (!hc_lat_nr && k < 80);
        checks++; if (low != 0) begin errors++; $display("FAIL nr_cs_stays_high: got %0d low cycles want 0", low); end
        checks++; if (k != 33) begin errors++; $display("FAIL nr_run_1cycle: got %0d want 33", k); end
        @(negedge clk);
        checks++; if (col_nr !== 8'd1) begin errors++; $display("FAIL nr_col_restart: got %0d want 1", col_nr); end
        checks++; if (loaded_nr !== 1'b1) begin errors++; $display("FAIL nr_loaded_kept: got %b want 1", loaded_nr); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_forward();
        test_reverse();
        test_overrun();
        test_abort();
        test_latch_edge();
        test_no_reload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
